// File: rtl/irq_grant_decoder_pkg.sv
// Shared types and helpers for the interrupt grant decoder.
// Optional statistics are enabled with IRQ_GRANT_DECODER_STATS_EN.
package irq_grant_pkg;

  localparam int NBANK = 3;
  localparam int NCHAN = 9;
  localparam int NREQ  = NBANK * NCHAN;

  // Limits at the width of the grant fields, so range checks stay unsigned.
  localparam logic [1:0] BANK_LIM = 2'(NBANK);
  localparam logic [3:0] CHAN_LIM = 4'(NCHAN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Flat request index: bank * NCHAN + chan.
  function automatic logic [4:0] flat_idx(input logic [1:0] bank, input logic [3:0] chan);
    return (5'(bank) * 5'(NCHAN)) + 5'(chan);
  endfunction

  // True when the grant names an existing requester.
  function automatic logic in_range(input logic [1:0] bank, input logic [3:0] chan);
    return (bank < BANK_LIM) && (chan < CHAN_LIM);
  endfunction

endpackage

// File: rtl/irq_grant_decoder_if.sv
// Grant / request / acknowledge bundle between the priority encoder,
// the request sources and the grant decoder.
// Statistics ports exist only with IRQ_GRANT_DECODER_STATS_EN.
interface irq_grant_decoder_if;
  import irq_grant_pkg::*;

  logic                  grant_valid;
  logic [1:0]            grant_bank;
  logic [3:0]            grant_chan;
  logic                  grant_ready;
  logic [NREQ-1:0]       req_in;
  logic [NREQ-1:0]       ack_out;
  logic                  busy;
  logic [4:0]            cur_idx;
  logic                  done_pulse;
  logic                  timeout_pulse;
  logic                  err_pulse;
`ifdef IRQ_GRANT_DECODER_STATS_EN
  logic                  stats_clr;
  logic [16*NBANK-1:0]   svc_count;
`endif

  // Encoder and request-source side.
  modport master (
    output grant_valid, grant_bank, grant_chan, req_in,
    input  grant_ready, ack_out, busy, cur_idx,
    input  done_pulse, timeout_pulse, err_pulse
`ifdef IRQ_GRANT_DECODER_STATS_EN
    , output stats_clr
    , input  svc_count
`endif
  );

  // Decoder side.
  modport slave (
    input  grant_valid, grant_bank, grant_chan, req_in,
    output grant_ready, ack_out, busy, cur_idx,
    output done_pulse, timeout_pulse, err_pulse
`ifdef IRQ_GRANT_DECODER_STATS_EN
    , input  stats_clr
    , output svc_count
`endif
  );

endinterface

// File: rtl/irq_grant_decoder_ack_timer.sv
// Loadable down-counter with a registered zero flag. Counting stops at
// zero; a load always wins over a decrement.
module irq_ack_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_r;
  logic         zero_r;

  // Counter and zero flag, updated together so zero never lags the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
      zero_r  <= 1'b1;
    end else if (load) begin
      count_r <= load_val;
      zero_r  <= (load_val == {W{1'b0}});
    end else if (dec && !zero_r) begin
      count_r <= count_r - W'(1);
      zero_r  <= (count_r == W'(1));
    end else begin
      count_r <= count_r;
      zero_r  <= zero_r;
    end
  end

  assign zero = zero_r;

endmodule

// File: rtl/irq_grant_decoder.sv
// Interrupt grant decoder: turns a {bank, channel} grant into a one-hot
// acknowledge held until the request drops or a timeout expires.
// Optional per-bank completion counters: IRQ_GRANT_DECODER_STATS_EN.
module irq_grant_decoder
  import irq_grant_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic              CK,
  input logic              RST_N,
  irq_grant_decoder_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT);

  state_t          state_r;
  logic [NREQ-1:0] ack_r;
  logic [4:0]      cur_idx_r;
  logic            grant_ready_r;
  logic            busy_r;
  logic            done_r;
  logic            timeout_r;
  logic            err_r;

  logic [4:0]      idx_s;
  logic            accept_s;
  logic            reject_s;
  logic            req_hit_s;
  logic            dec_s;
  logic            done_evt_s;
  logic            zero_s;

  // Grant qualification and ACK-phase decisions from current state and inputs.
  always_comb begin
    idx_s      = flat_idx(bus.grant_bank, bus.grant_chan);
    accept_s   = 1'b0;
    reject_s   = 1'b0;
    req_hit_s  = bus.req_in[cur_idx_r];
    dec_s      = 1'b0;
    done_evt_s = 1'b0;
    if (state_r == IDLE && bus.grant_valid) begin
      if (in_range(bus.grant_bank, bus.grant_chan)) begin
        accept_s = 1'b1;
      end else begin
        reject_s = 1'b1;
      end
    end else if (state_r == ACK) begin
      done_evt_s = !req_hit_s;
      dec_s      = req_hit_s && !zero_s;
    end else begin
      accept_s = 1'b0;
    end
  end

  irq_ack_timer #(.W(TW)) u_timer (
    .clk      (CK),
    .rst_n    (RST_N),
    .load     (accept_s),
    .load_val (TW'(TIMEOUT - 1)),
    .dec      (dec_s),
    .zero     (zero_s)
  );

  // Service FSM with registered acknowledge, status and pulse outputs.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_r       <= IDLE;
      ack_r         <= {NREQ{1'b0}};
      cur_idx_r     <= 5'd0;
      grant_ready_r <= 1'b1;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      timeout_r     <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      err_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r       <= ACK;
            cur_idx_r     <= idx_s;
            ack_r         <= {{(NREQ-1){1'b0}}, 1'b1} << idx_s;
            grant_ready_r <= 1'b0;
            busy_r        <= 1'b1;
          end else if (reject_s) begin
            err_r <= 1'b1;
          end
        end
        ACK: begin
          // A request drop beats an expiring timer in the same cycle.
          if (done_evt_s) begin
            state_r <= RELEASE;
            ack_r   <= {NREQ{1'b0}};
            done_r  <= 1'b1;
          end else if (zero_s) begin
            state_r   <= RELEASE;
            ack_r     <= {NREQ{1'b0}};
            timeout_r <= 1'b1;
          end
        end
        RELEASE: begin
          state_r       <= IDLE;
          grant_ready_r <= 1'b1;
          busy_r        <= 1'b0;
        end
        default: begin
          state_r       <= IDLE;
          ack_r         <= {NREQ{1'b0}};
          grant_ready_r <= 1'b1;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_ready   = grant_ready_r;
  assign bus.ack_out       = ack_r;
  assign bus.busy          = busy_r;
  assign bus.cur_idx       = cur_idx_r;
  assign bus.done_pulse    = done_r;
  assign bus.timeout_pulse = timeout_r;
  assign bus.err_pulse     = err_r;

`ifdef IRQ_GRANT_DECODER_STATS_EN
  logic [1:0]  cur_bank_r;
  logic [15:0] cnt_r [NBANK];

  // Bank of the grant in service, kept alongside cur_idx for the counters.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      cur_bank_r <= 2'd0;
    end else if (accept_s) begin
      cur_bank_r <= bus.grant_bank;
    end else begin
      cur_bank_r <= cur_bank_r;
    end
  end

  // Saturating per-bank count of services completed by request drop.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      for (int b = 0; b < NBANK; b++) cnt_r[b] <= 16'd0;
    end else if (bus.stats_clr) begin
      for (int b = 0; b < NBANK; b++) cnt_r[b] <= 16'd0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (done_evt_s && (cur_bank_r == 2'(b)) && (cnt_r[b] != 16'hFFFF)) begin
          cnt_r[b] <= cnt_r[b] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NBANK; g++) begin : g_cnt
    assign bus.svc_count[16*g +: 16] = cnt_r[g];
  end
`endif

endmodule

// File: tb/tb_irq_grant_decoder.sv
// Self-checking bench for irq_grant_decoder (randomised services against a
// cycle-count model). Build with IRQ_GRANT_DECODER_STATS_EN to cover stats.
module tb_irq_grant_decoder;

  localparam int NB   = 3;
  localparam int NC   = 9;
  localparam int TMO  = 16;

  logic CK;
  logic RST_N;
  int   errors = 0;
  int   checks = 0;
  int   last_idx = 0;
  int   exp_cnt [NB];

  irq_grant_decoder_if bus ();

  irq_grant_decoder #(.TIMEOUT(TMO)) dut (
    .CK    (CK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  task automatic clear_model();
    for (int b = 0; b < NB; b++) exp_cnt[b] = 0;
  endtask

  task automatic check_stats(input string nm);
`ifdef IRQ_GRANT_DECODER_STATS_EN
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (bus.svc_count[16*b +: 16] !== 16'(exp_cnt[b])) begin
        errors++;
        $display("FAIL %s svc_count[%0d]: got %0d, required %0d", nm, b,
                 bus.svc_count[16*b +: 16], exp_cnt[b]);
      end
    end
`else
    if (nm.len() < 0) $display("%s", nm);
`endif
  endtask

  // One grant held for h ACK cycles; outcome and length from plain arithmetic.
  task automatic run_service(input int b, input int c, input int h, input string nm);
    int          idx;
    int          exp_len;
    int          n_ack;
    bit          exp_done;
    bit          bad;
    logic [26:0] exp_ack;
    idx      = b * NC + c;
    exp_done = (h < TMO);
    exp_len  = exp_done ? h + 1 : TMO;
    exp_ack  = 27'd1 << idx;
    bus.grant_valid = 1'b1;
    bus.grant_bank  = 2'(b);
    bus.grant_chan  = 4'(c);
    bus.req_in      = 27'($urandom) | exp_ack;
    @(posedge CK); #1;
    bus.grant_valid = 1'b0;
    bus.grant_bank  = 2'($urandom);
    bus.grant_chan  = 4'($urandom);
    checks++;
    if (bus.ack_out !== exp_ack || bus.busy !== 1'b1 || bus.grant_ready !== 1'b0 ||
        bus.cur_idx !== 5'(idx)) begin
      errors++;
      $display("FAIL %s first_ack: ack=%h busy=%b ready=%b idx=%0d, required ack=%h busy=1 ready=0 idx=%0d",
               nm, bus.ack_out, bus.busy, bus.grant_ready, bus.cur_idx, exp_ack, idx);
    end
    n_ack = 1;
    bad   = 1'b0;
    for (int k = 0; k < 64; k++) begin
      bus.req_in      = 27'($urandom);
      bus.req_in[idx] = (k < h);
      @(posedge CK); #1;
      if (bus.ack_out === 27'd0) break;
      if (bus.ack_out !== exp_ack || bus.done_pulse !== 1'b0 || bus.timeout_pulse !== 1'b0) bad = 1'b1;
      n_ack++;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s ack_hold: ack or pulses wrong during service, required ack=%h and no pulses", nm, exp_ack);
    end
    checks++;
    if (n_ack != exp_len) begin
      errors++;
      $display("FAIL %s ack_length: got %0d cycles, required %0d", nm, n_ack, exp_len);
    end
    checks++;
    if (bus.done_pulse !== exp_done || bus.timeout_pulse !== !exp_done ||
        bus.busy !== 1'b1 || bus.grant_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s release: done=%b tmo=%b busy=%b ready=%b, required done=%b tmo=%b busy=1 ready=0",
               nm, bus.done_pulse, bus.timeout_pulse, bus.busy, bus.grant_ready, exp_done, !exp_done);
    end
    if (exp_done) exp_cnt[b] = exp_cnt[b] + 1;
    last_idx = idx;
    bus.req_in = 27'($urandom);
    @(posedge CK); #1;
    checks++;
    if (bus.grant_ready !== 1'b1 || bus.busy !== 1'b0 || bus.ack_out !== 27'd0 ||
        bus.done_pulse !== 1'b0 || bus.timeout_pulse !== 1'b0 || bus.cur_idx !== 5'(idx)) begin
      errors++;
      $display("FAIL %s back_idle: ready=%b busy=%b ack=%h done=%b tmo=%b idx=%0d, required ready=1 busy=0 ack=0 no pulses idx=%0d",
               nm, bus.grant_ready, bus.busy, bus.ack_out, bus.done_pulse, bus.timeout_pulse, bus.cur_idx, idx);
    end
    check_stats(nm);
  endtask

  task automatic test_err(input int b, input int c, input string nm);
    bus.grant_valid = 1'b1;
    bus.grant_bank  = 2'(b);
    bus.grant_chan  = 4'(c);
    bus.req_in      = 27'($urandom);
    @(posedge CK); #1;
    bus.grant_valid = 1'b0;
    checks++;
    if (bus.err_pulse !== 1'b1 || bus.ack_out !== 27'd0 || bus.grant_ready !== 1'b1 ||
        bus.busy !== 1'b0 || bus.cur_idx !== 5'(last_idx)) begin
      errors++;
      $display("FAIL %s err: err=%b ack=%h ready=%b busy=%b idx=%0d, required err=1 ack=0 ready=1 busy=0 idx=%0d",
               nm, bus.err_pulse, bus.ack_out, bus.grant_ready, bus.busy, bus.cur_idx, last_idx);
    end
    @(posedge CK); #1;
    checks++;
    if (bus.err_pulse !== 1'b0 || bus.ack_out !== 27'd0 || bus.grant_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s err_clear: err=%b ack=%h ready=%b, required err=0 ack=0 ready=1",
               nm, bus.err_pulse, bus.ack_out, bus.grant_ready);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    bus.grant_valid = 1'b0;
    bus.grant_bank  = 2'd0;
    bus.grant_chan  = 4'd0;
    bus.req_in      = 27'd0;
`ifdef IRQ_GRANT_DECODER_STATS_EN
    bus.stats_clr   = 1'b0;
`endif
    clear_model();
    last_idx = 0;
    repeat (3) @(posedge CK);
    #1;
    checks++;
    if (bus.ack_out !== 27'd0 || bus.busy !== 1'b0 || bus.cur_idx !== 5'd0 ||
        bus.grant_ready !== 1'b1 || bus.done_pulse !== 1'b0 ||
        bus.timeout_pulse !== 1'b0 || bus.err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ack=%h busy=%b idx=%0d ready=%b pulses=%b%b%b, required all 0 and ready=1",
               bus.ack_out, bus.busy, bus.cur_idx, bus.grant_ready,
               bus.done_pulse, bus.timeout_pulse, bus.err_pulse);
    end
    check_stats("reset");
    #3 RST_N = 1'b1;
    @(posedge CK); #1;
    checks++;
    if (bus.grant_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b, required ready=1 busy=0", bus.grant_ready, bus.busy);
    end
  endtask

  task automatic test_reset_mid_ack();
    bus.grant_valid = 1'b1;
    bus.grant_bank  = 2'd1;
    bus.grant_chan  = 4'd2;
    bus.req_in      = 27'h7FF_FFFF;
    @(posedge CK); #1;
    bus.grant_valid = 1'b0;
    @(posedge CK); #1;
    checks++;
    if (bus.ack_out !== (27'd1 << 11)) begin
      errors++;
      $display("FAIL mid_ack_pre: ack=%h, required %h", bus.ack_out, 27'd1 << 11);
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (bus.ack_out !== 27'd0 || bus.busy !== 1'b0 || bus.grant_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_ack_async: ack=%h busy=%b ready=%b, required ack=0 busy=0 ready=1",
               bus.ack_out, bus.busy, bus.grant_ready);
    end
    clear_model();
    last_idx = 0;
    @(posedge CK);
    #3 RST_N = 1'b1;
    @(posedge CK); #1;
    checks++;
    if (bus.grant_ready !== 1'b1 || bus.ack_out !== 27'd0 || bus.cur_idx !== 5'd0) begin
      errors++;
      $display("FAIL mid_ack_release: ready=%b ack=%h idx=%0d, required ready=1 ack=0 idx=0",
               bus.grant_ready, bus.ack_out, bus.cur_idx);
    end
    bus.req_in = 27'd0;
    check_stats("mid_ack_reset");
  endtask

  task automatic test_back_to_back();
    run_service(2, 3, 0, "b2b_a");
    run_service(2, 4, 1, "b2b_b");
    run_service(0, 8, 2, "b2b_c");
  endtask

  task automatic test_random();
    int b;
    int c;
    int h;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          b = 3;
          c = $urandom_range(0, 15);
        end else begin
          b = $urandom_range(0, 3);
          c = $urandom_range(9, 15);
        end
        test_err(b, c, "rand_err");
      end else begin
        b = $urandom_range(0, NB - 1);
        c = $urandom_range(0, NC - 1);
        h = $urandom_range(0, 20);
        run_service(b, c, h, "rand_svc");
      end
    end
  endtask

`ifdef IRQ_GRANT_DECODER_STATS_EN
  task automatic pulse_stats_clr();
    bus.stats_clr = 1'b1;
    @(posedge CK); #1;
    bus.stats_clr = 1'b0;
    clear_model();
  endtask

  task automatic test_stats();
    pulse_stats_clr();
    check_stats("stats_clr_a");
    run_service(2, 0, 1, "stats_d1");
    run_service(2, 5, 3, "stats_d2");
    run_service(2, 8, 0, "stats_d3");
    run_service(2, 1, 30, "stats_tmo");
    checks++;
    if (bus.svc_count[47:32] !== 16'd3 || bus.svc_count[31:0] !== 32'd0) begin
      errors++;
      $display("FAIL stats_bank2: svc_count=%h, required bank2=3 others 0", bus.svc_count);
    end
    pulse_stats_clr();
    checks++;
    if (bus.svc_count !== 48'd0) begin
      errors++;
      $display("FAIL stats_clr_b: svc_count=%h, required 0", bus.svc_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    run_service(1, 4, 3, "basic_idx13");
    run_service(0, 0, 3, "hold_drop_idx0");
    run_service(2, 8, 1000, "timeout_idx26");
    test_err(3, 0, "bank3");
    test_err(0, 9, "chan9");
    run_service(1, 7, TMO - 1, "last_cycle_drop");
    run_service(0, 5, TMO, "first_timeout_len");
    test_back_to_back();
    test_random();
`ifdef IRQ_GRANT_DECODER_STATS_EN
    test_stats();
`endif
    test_reset_mid_ack();
    run_service(1, 1, 2, "after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_grant_decoder.md
Name: irq_grant_decoder

Overview:
- Reverse side of the team's 27-input, 3-bank interrupt priority encoder (9 channels per bank).
- Takes a registered grant {bank, channel} from the encoder and drives a one-hot acknowledge back to the winning requester.
- Holds the acknowledge until the requester withdraws its request, or until a timeout expires.
- Sits between the priority encoder output and the request sources. Serialises one grant at a time.

Parameters:
- NBANK, 3, number of request banks.
- NCHAN, 9, channels per bank.
- TIMEOUT, 16, max cycles ACK is held waiting for request drop (>=2).

Ports:
- CK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- grant_valid  in  1  encoder presents a grant.
- grant_bank  in  2  bank index (0..NBANK-1).
- grant_chan  in  4  channel index within bank (0..NCHAN-1).
- grant_ready  out  1  decoder can accept a grant.
- req_in  in  NBANK*NCHAN  live request lines; bit = bank*NCHAN+chan.
- ack_out  out  NBANK*NCHAN  one-hot acknowledge.
- busy  out  1  a grant is in service.
- cur_idx  out  5  flat index of the grant in service.
- done_pulse  out  1  one cycle: service completed by request drop.
- timeout_pulse  out  1  one cycle: service aborted by timeout.
- err_pulse  out  1  one cycle: out-of-range grant rejected.

Behaviour:
- Reset is asynchronous on RST_N low. Reset values:
  - ack_out=0, busy=0, cur_idx=0, all pulses 0.
  - grant_ready=1, because reset returns the FSM to IDLE.
- Reset mid-service drops ack_out immediately and returns to IDLE.
- States:
  - IDLE: grant_ready=1, busy=0.
  - ACK: grant_ready=0, busy=1.
  - RELEASE: grant_ready=0, busy=1.
- IDLE transitions:
  - If grant_valid=1 and grant_bank<NBANK and grant_chan<NCHAN:
    - latch idx = grant_bank*NCHAN + grant_chan (5-bit, unsigned);
    - cur_idx<=idx; load timer=TIMEOUT-1; go to ACK.
  - If grant_valid=1 and the index is out of range: err_pulse=1 next cycle, stay in IDLE, no ack.
- ACK:
  - ack_out = 1<<cur_idx, registered. ack_out is first high in the cycle after acceptance, so latency from grant to ack is 1 cycle.
  - ACK lasts at least 1 cycle, even if req_in[cur_idx] is already 0.
  - Each cycle in ACK:
    - req_in[cur_idx]=0: go to RELEASE.
    - else timer==0: go to RELEASE with the timeout flag set.
    - else timer decrements.
  - If the request drops in the same cycle the timer reaches 0, the outcome is done, not timeout.
- RELEASE (one cycle):
  - ack_out=0.
  - done_pulse or timeout_pulse=1 (exactly one).
  - Next state is IDLE, so the next grant can be accepted 2 cycles after the request drop is sampled.
- grant_valid while grant_ready=0 is ignored. The encoder holds grant_valid until ready.
- ack_out is never multi-hot. It is zero in IDLE and RELEASE.
- cur_idx holds its last value in IDLE.

Optional Feature:
- Macro: IRQ_GRANT_DECODER_STATS_EN.
- When defined:
  - Adds output svc_count, 16 bits × NBANK, flattened.
  - Adds input stats_clr (1 bit, synchronous clear).
  - Each RELEASE with the done outcome increments the counter of the bank of cur_idx. Counters saturate at 0xFFFF.
  - Timeouts are not counted.
  - Reset and stats_clr both clear all counters.
- When undefined: these ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package irq_grant_pkg holds:
  - state enum {IDLE, ACK, RELEASE};
  - localparam NREQ=NBANK*NCHAN;
  - function flat_idx(bank,chan);
  - function in_range(bank,chan).
- One sub-module, irq_ack_timer: loadable down-counter with a zero flag, reused by other handshake blocks.
- The FSM and ack register stay in the top module.

Test Plan:
- Reset, then grant bank=1 chan=4 (idx 13) with req_in[13]=1 → ack_out[13]=1 one cycle later, other bits 0, busy=1.
- Grant bank=0 chan=0 with req_in[0] held 1 for 3 more cycles, then dropped → ack deasserts the cycle after the drop is sampled, done_pulse=1 once, grant_ready=1 the following cycle.
- Grant idx 26, req_in[26] never drops, TIMEOUT=16 → ack high exactly 16 cycles, timeout_pulse=1, done_pulse=0.
- Grant bank=3 chan=0, then bank=0 chan=9 → err_pulse=1 each time, ack_out stays 0, stays in IDLE.
- Request drop on the final timeout cycle → done_pulse=1, timeout_pulse=0. Separately, RST_N low during ACK → ack_out=0 asynchronously, grant_ready=1 after reset release.
- With IRQ_GRANT_DECODER_STATS_EN: 3 done services on bank 2 plus 1 timeout → svc_count[2]=3. Then stats_clr=1 → all counters 0.
